// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: round-robin arbiter sharing a single-port data RAM between bus masters
module ram_bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*AW-1:0]   m_addr,
  input  logic [NREQ*DW-1:0]   m_wdata,
  input  logic [NREQ-1:0]      m_wen,
  output logic [NREQ-1:0]      grant,
  output logic [1:0]           owner,
  output logic                 busy,
  output logic [AW-1:0]        ram_rw_addr,
  output logic [DW-1:0]        ram_w,
  output logic                 ram_w_en
);
  localparam int HW = MAX_HOLD < 2 ? 1 : $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HCAP = MAX_HOLD == 0 ? {HW{1'b1}} : HW'(MAX_HOLD - 1);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t          state;
  logic [1:0]      ptr, pick;
  logic [HW-1:0]   hold_cnt;
  logic [NREQ-1:0] cand;
  logic            own_req, own_lock, rotate, move;
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] c, input logic [1:0] p);
    logic [1:0]      r;
    logic [1:0]      idx;
    logic [NREQ-1:0] s;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = 2'((int'(p) + k) % NREQ);
      s = c >> idx;
      if (s[0]) r = idx;
    end
    return r;
  endfunction
  // arbitration decision: who is eligible and whether the grant moves at the next edge
  always_comb begin
    own_req  = |(req & grant);
    own_lock = |(lock & grant);
    cand     = state == OWNED ? req & ~grant : req;
    rotate   = MAX_HOLD != 0 && hold_cnt == HCAP && !own_lock && |cand;
    move     = state == IDLE || !own_req || rotate;
    pick     = rr_pick(cand, ptr);
  end
  // grant register: hold while owner keeps requesting, otherwise hand over without a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else if (!move) begin
      hold_cnt <= hold_cnt == HCAP ? hold_cnt : hold_cnt + 1'b1;
    end else if (|cand) begin
      state    <= OWNED;
      grant    <= NREQ'(1) << pick;
      owner    <= pick;
      ptr      <= int'(pick) == NREQ - 1 ? 2'd0 : pick + 2'd1;
      hold_cnt <= '0;
    end else begin
      state    <= IDLE;
      grant    <= '0;
      hold_cnt <= '0;
    end
  end
  // RAM port steering straight from the registered owner, zeroed when idle
  always_comb begin
    busy        = |grant;
    ram_rw_addr = busy ? AW'(m_addr >> (int'(owner) * AW)) : '0;
    ram_w       = busy ? DW'(m_wdata >> (int'(owner) * DW)) : '0;
    ram_w_en    = |(m_wen & grant);
  end
  a_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
endmodule
